// File: rtl/jk_mod_counter_if.sv
// Control and observation bundle for jk_mod_counter.
// Ports (slave view, as seen by the counter):
//   clr, load, en, up : control inputs (active-high)
//   din               : parallel load value
//   count             : registered count value
//   tc                : combinational terminal count for cascading
//   ovf               : sticky wrap flag
//   j_vec, k_vec      : per-bit J/K drive applied at the next edge
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  modport master (
    output clr, load, din, en, up,
    input  count, tc, ovf, j_vec, k_vec
  );

  modport slave (
    input  clr, load, din, en, up,
    output count, tc, ovf, j_vec, k_vec
  );
endinterface

// File: rtl/jk_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter built from JK storage stages.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (count and ovf cleared at once)
//   bus   : jk_mod_counter_if.slave carrying clr/load/din/en/up in and
//           count/tc/ovf/j_vec/k_vec out
// Priority at each edge: clr > load > en > hold. Loads above MODULUS-1
// clamp to MODULUS-1. Counting wraps at MODULUS boundaries and sets ovf,
// which stays set until clr or reset. Constraint: 2 <= MODULUS <= 2**WIDTH.

// Single JK storage bit with asynchronous active-low clear.
module jk_stage (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= (j & ~q) | (~k & q);
  end
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic              clk,
  input logic              reset,
  jk_mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] j_int;
  logic [WIDTH-1:0] k_int;
  logic             at_top;
  logic             at_bot;
  logic             wrap;
  logic             ovf_q;

  assign at_top = (count_q == MAX_VAL);
  assign at_bot = (count_q == '0);

  // A wrap is only possible when counting is the operation that wins
  // priority, so clr/load suppress it (and tc along with it).
  assign wrap = bus.en & ~bus.clr & ~bus.load &
                ((bus.up & at_top) | (~bus.up & at_bot));

  always_comb begin
    next_count = count_q;
    if (bus.clr) begin
      next_count = '0;
    end else if (bus.load) begin
      next_count = (bus.din > MAX_VAL) ? MAX_VAL : bus.din;
    end else if (bus.en) begin
      if (bus.up) next_count = at_top ? '0 : count_q + WIDTH'(1);
      else        next_count = at_bot ? MAX_VAL : count_q - WIDTH'(1);
    end
  end

  // J sets bits that must rise, K clears bits that must fall; a bit that
  // keeps its value gets neither, so J and K are never both high.
  always_comb begin
    j_int = '0;
    k_int = '0;
    if (reset) begin
      j_int = next_count & ~count_q;
      k_int = ~next_count & count_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .j     (j_int[i]),
      .k     (k_int[i]),
      .q     (count_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf_q <= 1'b0;
    else if (bus.clr) ovf_q <= 1'b0;
    else if (wrap)    ovf_q <= 1'b1;
  end

  assign bus.count = count_q;
  assign bus.tc    = wrap;
  assign bus.ovf   = ovf_q;
  assign bus.j_vec = j_int;
  assign bus.k_vec = k_int;
endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous WIDTH-bit modulo-MODULUS up/down counter.
- Each count bit is a JK-style storage stage; per-bit J/K drive vectors are computed from the current and next count, and the bits update on the rising clock edge.
- Directly consumes the JK flip-flop stage and forms the counter layer of the lab counter designs.
- Provides a cascade terminal-count output and a sticky overflow flag for a downstream display or next-digit stage.

Parameters:
- WIDTH, 4, count register width in bits.
- MODULUS, 10, count range is 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- clr  input  1  synchronous clear, active-high.
- load  input  1  synchronous parallel load, active-high.
- din  input  WIDTH  load value.
- en  input  1  count enable, active-high.
- up  input  1  direction: 1 = up, 0 = down.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal count for cascading; combinational.
- ovf  output  1  sticky wrap flag; registered.
- j_vec  output  WIDTH  per-bit J drive for the next edge; combinational.
- k_vec  output  WIDTH  per-bit K drive for the next edge; combinational.

Behaviour:
- Reset:
  - reset = 0 forces count = 0 and ovf = 0 immediately, independent of clk.
  - While reset is low, all other inputs are ignored.
  - Release of reset is sampled on the next rising edge; the first update after release is on that edge.
- Priority at each rising edge, highest first: clr, then load, then en, then hold.
- clr = 1:
  - next count = 0.
  - ovf cleared to 0.
  - load and en are ignored.
- load = 1 (with clr = 0):
  - next count = din if din <= MODULUS-1.
  - If din > MODULUS-1, next count = MODULUS-1 (clamp).
  - ovf unchanged; en ignored.
- en = 1, up = 1:
  - next count = count+1.
  - If count = MODULUS-1: next count = 0 and ovf is set to 1.
- en = 1, up = 0:
  - next count = count-1.
  - If count = 0: next count = MODULUS-1 and ovf is set to 1.
- en = 0: hold.
- Direction change: up may change on any cycle. The new direction applies on the next edge; no turnaround cycle.
- Latency: count reflects the operation one edge after the inputs are sampled.
- tc:
  - tc = en & ((up & count == MODULUS-1) | (~up & count == 0)).
  - tc is low whenever clr or load is asserted.
  - tc is high exactly in the cycle before a wrap edge.
- ovf: once set, stays 1 until clr or reset. A wrap in the same cycle as clr cannot happen because clr has priority.
- J/K drive, with next = next-count value from the rules above:
  - j_vec = next & ~count.
  - k_vec = ~next & count.
  - A bit that holds has J = K = 0. No bit ever has J = K = 1.
  - Count bits update as q <= (J & ~q) | (~K & q).
  - j_vec and k_vec are 0 while reset is low.
- Arithmetic:
  - Unsigned WIDTH-bit arithmetic.
  - Wrap is to MODULUS boundaries, not 2**WIDTH. When MODULUS = 2**WIDTH the two coincide.
  - count never leaves 0..MODULUS-1.
- Reset mid-operation: asserting reset in any cycle, including with load or clr high, gives count = 0 and ovf = 0 within the same cycle. No partial update occurs.

Test Plan (WIDTH = 4, MODULUS = 10 unless stated):
- Hold reset low for 2 cycles, then release; en = 1, up = 1 for 12 edges -> count 0 after reset, then 1,2,...,9,0,1,2. tc = 1 only while count = 9. ovf goes 0 -> 1 on the 9 -> 0 edge.
- From count 0, en = 1, up = 0 -> count 9, 8, 7. tc = 1 during count = 0. ovf = 1 after the first edge.
- load = 1, din = 6 -> count 6. load = 1, din = 13 -> count 9 (clamped). load = 1 and en = 1 together -> load wins. ovf unchanged throughout.
- count = 5, clr = 1, load = 1, en = 1 -> count 0, ovf 0, tc 0. Repeat with clr low and en = 0 for 3 edges -> count holds, j_vec = k_vec = 0.
- count = 7 (0111), en = 1, up = 1 -> before the edge j_vec = 1000, k_vec = 0111; after the edge count = 8. Check every cycle that (j_vec & k_vec) == 0.
- Mid-count (count = 4), drop reset between clock edges -> count 0 and ovf 0 immediately, with no clk edge needed. With MODULUS = 16, count 15 up -> 0 and ovf = 1.
